obi_magic_bridge: RTL and testbench

Converts the core's OBI-style request/grant/rvalid port, used for both instruction fetch and load/store, into the single-outstanding read/write/resp handshake of the magic and burst-less simulation memory. It sits between the core's `instr_*` or `data_*` port and the memory-side signals of `tb_itf`, one instance per port. It replaces tying gnt and rvalid to the same resp wire. Requests are buffered, issued one at a time, and answered in order. A timeout returns an error instead of hanging the core.

---
 rtl/obi_bridge_pkg.sv | 20 ++
 rtl/obi_req_fifo.sv | 45 ++++
 rtl/obi_magic_bridge.sv | 125 ++++++++++++
 tb/tb_obi_magic_bridge.sv | 480 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/obi_bridge_pkg.sv
// Shared types for the OBI-to-magic-memory bridge: request record, FSM states and bus widths.
package obi_bridge_pkg;

  localparam int unsigned OBI_AW = 32;
  localparam int unsigned OBI_DW = 32;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } bridge_state_e;

  typedef struct packed {
    logic [OBI_AW-1:0]   addr;
    logic                we;
    logic [OBI_DW/8-1:0] be;
    logic [OBI_DW-1:0]   wdata;
  } obi_req_t;

endpackage

// File: rtl/obi_req_fifo.sv
// Request FIFO for the bridge: registered storage, no bypass, full/empty from registered pointers.
module obi_req_fifo
  import obi_bridge_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push_i,
  input  obi_req_t data_i,
  input  logic     pop_i,
  output obi_req_t head_o,
  output logic     full_o,
  output logic     empty_o
);

  // One extra pointer bit separates full from empty; DEPTH=1 still gets a 1-bit index.
  localparam int unsigned IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned Slots = 2 ** IW;

  obi_req_t      mem_q [Slots];
  logic [IW:0]   wr_ptr_q, rd_ptr_q;
  logic [IW:0]   fill;

  assign fill    = wr_ptr_q - rd_ptr_q;
  assign full_o  = (fill == (IW + 1)'(DEPTH));
  assign empty_o = (fill == '0);
  assign head_o  = mem_q[rd_ptr_q[IW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_i && !full_o) begin
        mem_q[wr_ptr_q[IW-1:0]] <= data_i;
        wr_ptr_q                <= wr_ptr_q + 1'b1;
      end
      if (pop_i && !empty_o) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/obi_magic_bridge.sv
// Adapts an OBI req/gnt/rvalid port to the single-outstanding read/write/resp magic memory,
// serving buffered requests in order and answering with an error after a wait timeout.
module obi_magic_bridge
  import obi_bridge_pkg::*;
#(
  parameter int unsigned DEPTH   = 2,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_i,
  output logic                gnt_o,
  input  logic [OBI_AW-1:0]   addr_i,
  input  logic                we_i,
  input  logic [OBI_DW/8-1:0] be_i,
  input  logic [OBI_DW-1:0]   wdata_i,
  output logic                rvalid_o,
  output logic [OBI_DW-1:0]   rdata_o,
  output logic                err_o,
  output logic                mem_read,
  output logic                mem_write,
  output logic [OBI_DW/8-1:0] mem_mbe,
  output logic [OBI_AW-1:0]   mem_addr,
  output logic [OBI_DW-1:0]   mem_wdata,
  input  logic                mem_resp,
  input  logic [OBI_DW-1:0]   mem_rdata
);

  localparam int unsigned   CW     = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CntMax = CW'(TIMEOUT - 1);

  bridge_state_e     state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [OBI_DW-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  logic     push, pop, full, empty;
  obi_req_t push_data, head;

  assign gnt_o     = req_i & ~full;
  assign push      = gnt_o;
  assign push_data = '{addr: addr_i, we: we_i, be: be_i, wdata: wdata_i};

  obi_req_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .data_i  (push_data),
    .pop_i   (pop),
    .head_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    pop       = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_mbe   = '0;
    mem_addr  = '0;
    mem_wdata = '0;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        // Leaving on the push edge puts the strobe in the cycle right after the grant.
        if (!empty || push) begin
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        mem_read  = ~head.we;
        mem_write = head.we;
        mem_mbe   = head.be;
        mem_addr  = {head.addr[OBI_AW-1:2], 2'b00};
        mem_wdata = head.wdata;
        if (mem_resp) begin
          rdata_d = head.we ? '0 : mem_rdata;
          err_d   = 1'b0;
          pop     = 1'b1;
          state_d = RESP;
        end else if (cnt_q == CntMax) begin
          rdata_d = '0;
          err_d   = 1'b1;
          pop     = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign rvalid_o = (state_q == RESP);
  assign rdata_o  = rdata_q;
  assign err_o    = err_q;

endmodule

// File: tb/tb_obi_magic_bridge.sv
// Self-checking bench for obi_magic_bridge: directed scenarios plus randomized traffic
// checked against an in-order transaction model and a behavioural magic memory.
module tb_obi_magic_bridge;

  localparam int unsigned DEPTH   = 2;
  localparam int unsigned TIMEOUT = 8;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } tb_req_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } tb_rsp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_i = 1'b0;
  logic        gnt_o;
  logic [31:0] addr_i = '0;
  logic        we_i = 1'b0;
  logic [3:0]  be_i = '0;
  logic [31:0] wdata_i = '0;
  logic        rvalid_o;
  logic [31:0] rdata_o;
  logic        err_o;
  logic        mem_read;
  logic        mem_write;
  logic [3:0]  mem_mbe;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_resp = 1'b0;
  logic [31:0] mem_rdata = '0;

  always #5 clk = ~clk;

  obi_magic_bridge #(
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_i     (req_i),
    .gnt_o     (gnt_o),
    .addr_i    (addr_i),
    .we_i      (we_i),
    .be_i      (be_i),
    .wdata_i   (wdata_i),
    .rvalid_o  (rvalid_o),
    .rdata_o   (rdata_o),
    .err_o     (err_o),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_mbe   (mem_mbe),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_resp  (mem_resp),
    .mem_rdata (mem_rdata)
  );

  logic [31:0] memory  [256];
  logic [31:0] ref_mem [256];
  bit          resp_en    = 1'b1;
  bit          late_resp  = 1'b0;
  int          resp_delay = 0;
  int          wcnt       = 0;
  int          n_checks   = 0;
  int          n_fail     = 0;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  // Magic memory: answers resp_delay cycles after the strobe first appears.
  always @(negedge clk) begin
    if (rst) begin
      mem_resp <= 1'b0;
      wcnt     <= 0;
    end else if ((mem_read || mem_write) && resp_en) begin
      if (wcnt >= resp_delay) begin
        mem_resp <= 1'b1;
        if (mem_read) mem_rdata <= memory[mem_addr[9:2]];
        else begin
          memory[mem_addr[9:2]] <= merge(memory[mem_addr[9:2]], mem_wdata, mem_mbe);
          mem_rdata             <= $urandom;
        end
        wcnt <= 0;
      end else begin
        mem_resp <= 1'b0;
        wcnt     <= wcnt + 1;
      end
    end else begin
      mem_resp  <= late_resp;
      mem_rdata <= $urandom;
      wcnt      <= 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic w, input logic [3:0] b,
                       input logic [31:0] d);
    req_i   = 1'b1;
    addr_i  = a;
    we_i    = w;
    be_i    = b;
    wdata_i = d;
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    req_i = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    n_checks++;
    if ({rvalid_o, err_o, mem_read, mem_write} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_flags: got rvalid/err/rd/wr=%b required 0000",
               {rvalid_o, err_o, mem_read, mem_write});
    end
    n_checks++;
    if ({rdata_o, mem_addr, mem_wdata, mem_mbe} !== '0) begin
      n_fail++;
      $display("FAIL reset_data: rdata=%h addr=%h wdata=%h mbe=%h required all 0",
               rdata_o, mem_addr, mem_wdata, mem_mbe);
    end
    req_i = 1'b1;
    #1;
    n_checks++;
    if (gnt_o !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_gnt_hi: got %b required 1", gnt_o);
    end
    req_i = 1'b0;
    #1;
    n_checks++;
    if (gnt_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_gnt_lo: got %b required 0", gnt_o);
    end
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_read();
    memory[8'h21]  = 32'hDEAD_BEEF;
    ref_mem[8'h21] = 32'hDEAD_BEEF;
    resp_delay     = 0;
    drive(32'h0000_0086, 1'b0, 4'hF, $urandom);
    @(negedge clk);
    n_checks++;
    if (gnt_o !== 1'b1) begin
      n_fail++;
      $display("FAIL read_gnt: got %b required 1", gnt_o);
    end
    tick();
    req_i = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({mem_read, mem_write, mem_mbe, mem_addr, rvalid_o} !== {2'b10, 4'hF, 32'h84, 1'b0}) begin
      n_fail++;
      $display("FAIL read_strobe: rd=%b wr=%b mbe=%h addr=%h rvalid=%b required 1 0 f 84 0",
               mem_read, mem_write, mem_mbe, mem_addr, rvalid_o);
    end
    tick();
    @(negedge clk);
    n_checks++;
    if ({mem_read, rvalid_o, rdata_o, err_o} !== {2'b01, 32'hDEAD_BEEF, 1'b0}) begin
      n_fail++;
      $display("FAIL read_rsp: rd=%b rvalid=%b rdata=%h err=%b required 0 1 deadbeef 0",
               mem_read, rvalid_o, rdata_o, err_o);
    end
    tick();
    @(negedge clk);
    n_checks++;
    if ({rvalid_o, rdata_o} !== {1'b0, 32'hDEAD_BEEF}) begin
      n_fail++;
      $display("FAIL read_hold: rvalid=%b rdata=%h required 0 deadbeef", rvalid_o, rdata_o);
    end
    tick();
  endtask

  task automatic test_write();
    int strobes = 0;
    resp_delay = 1;
    ref_mem[4] = merge(ref_mem[4], 32'h1234_5678, 4'h3);
    drive(32'h10, 1'b1, 4'h3, 32'h1234_5678);
    @(negedge clk);
    n_checks++;
    if (gnt_o !== 1'b1) begin
      n_fail++;
      $display("FAIL write_gnt: got %b required 1", gnt_o);
    end
    tick();
    req_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rvalid_o) break;
      if (mem_write) begin
        strobes++;
        n_checks++;
        if ({mem_read, mem_mbe, mem_addr, mem_wdata} !== {1'b0, 4'h3, 32'h10, 32'h1234_5678}) begin
          n_fail++;
          $display("FAIL write_strobe: rd=%b mbe=%h addr=%h wdata=%h required 0 3 10 12345678",
                   mem_read, mem_mbe, mem_addr, mem_wdata);
        end
      end
      tick();
    end
    n_checks++;
    if (strobes !== 2) begin
      n_fail++;
      $display("FAIL write_strobe_len: got %0d cycles required 2", strobes);
    end
    n_checks++;
    if ({rvalid_o, rdata_o, err_o} !== {1'b1, 32'h0, 1'b0}) begin
      n_fail++;
      $display("FAIL write_rsp: rvalid=%b rdata=%h err=%b required 1 0 0",
               rvalid_o, rdata_o, err_o);
    end
    tick();
  endtask

  // Streams n requests; the model predicts grants from occupancy and answers in grant order.
  task automatic run_traffic(input string name, input bit seq, input int n);
    tb_req_t reqs[$];
    tb_req_t acc_q[$];
    tb_rsp_t exp_q[$];
    tb_req_t r;
    tb_rsp_t e;
    int      grants = 0;
    int      rvs = 0;
    bit      prev_strobe = 1'b0;
    bit      strobe;
    bit      saw_block = 1'b0;
    logic    exp_gnt;

    for (int i = 0; i < n; i++) begin
      if (seq) begin
        r.addr = 32'(4 * i);
        r.we = 1'b0;
        r.be = 4'hF;
        r.wdata = $urandom;
      end else begin
        r.addr = $urandom;
        r.we = 1'($urandom_range(0, 1));
        r.be = 4'($urandom_range(1, 15));
        r.wdata = $urandom;
      end
      reqs.push_back(r);
    end

    for (int cyc = 0; cyc < 50 * n && rvs < n; cyc++) begin
      if (grants < n && (seq || $urandom_range(0, 3) != 0)) begin
        drive(reqs[grants].addr, reqs[grants].we, reqs[grants].be, reqs[grants].wdata);
      end else begin
        req_i = 1'b0;
      end
      @(negedge clk);
      exp_gnt = req_i && ((grants - rvs - int'(rvalid_o)) < int'(DEPTH));
      n_checks++;
      if (gnt_o !== exp_gnt) begin
        n_fail++;
        $display("FAIL %s_gnt: cycle %0d got %b required %b", name, cyc, gnt_o, exp_gnt);
      end
      if (req_i && !gnt_o) saw_block = 1'b1;
      if (rvalid_o) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL %s_rsp: unexpected rvalid rdata=%h required none", name, rdata_o);
        end else begin
          e = exp_q.pop_front();
          if ({rdata_o, err_o} !== {e.rdata, e.err}) begin
            n_fail++;
            $display("FAIL %s_rsp: rsp %0d got rdata=%h err=%b required rdata=%h err=%b",
                     name, rvs, rdata_o, err_o, e.rdata, e.err);
          end
        end
        rvs++;
      end
      strobe = mem_read | mem_write;
      if (strobe && !prev_strobe) begin
        n_checks++;
        if (acc_q.size() == 0) begin
          n_fail++;
          $display("FAIL %s_access: unexpected strobe addr=%h required none", name, mem_addr);
        end else begin
          r = acc_q.pop_front();
          if ({mem_addr, mem_write, mem_read, mem_mbe} !== {r.addr, r.we, ~r.we, r.be}
              || (r.we && mem_wdata !== r.wdata)) begin
            n_fail++;
            $display("FAIL %s_access: got addr=%h wr=%b rd=%b mbe=%h wdata=%h required addr=%h we=%b be=%h wdata=%h",
                     name, mem_addr, mem_write, mem_read, mem_mbe, mem_wdata,
                     r.addr, r.we, r.be, r.wdata);
          end
        end
      end
      prev_strobe = strobe;
      if (req_i && gnt_o) begin
        r = reqs[grants];
        r.addr[1:0] = 2'b00;
        acc_q.push_back(r);
        e.err = 1'b0;
        if (r.we) begin
          ref_mem[r.addr[9:2]] = merge(ref_mem[r.addr[9:2]], r.wdata, r.be);
          e.rdata = '0;
        end else begin
          e.rdata = ref_mem[r.addr[9:2]];
        end
        exp_q.push_back(e);
        grants++;
      end
      tick();
    end
    req_i = 1'b0;
    n_checks++;
    if (rvs !== n) begin
      n_fail++;
      $display("FAIL %s_count: got %0d responses required %0d", name, rvs, n);
    end
    if (seq) begin
      n_checks++;
      if (saw_block !== 1'b1) begin
        n_fail++;
        $display("FAIL %s_backpressure: got gnt never low required low while queue full", name);
      end
    end
    repeat (2) tick();
  endtask

  task automatic test_back_to_back();
    resp_delay = 2;
    run_traffic("b2b", 1'b1, 3);
  endtask

  task automatic test_random();
    for (int k = 0; k < 4; k++) begin
      resp_delay = $urandom_range(0, 3);
      run_traffic("rand", 1'b0, 12);
    end
  endtask

  task automatic test_timeout();
    int strobes = 0;
    resp_en = 1'b0;
    drive(32'h40, 1'b0, 4'hF, '0);
    @(negedge clk);
    n_checks++;
    if (gnt_o !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_gnt: got %b required 1", gnt_o);
    end
    tick();
    req_i = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rvalid_o) break;
      if (mem_read) strobes++;
      tick();
    end
    n_checks++;
    if (strobes !== int'(TIMEOUT)) begin
      n_fail++;
      $display("FAIL timeout_len: got %0d strobe cycles required %0d", strobes, TIMEOUT);
    end
    n_checks++;
    if ({rvalid_o, err_o, rdata_o} !== {2'b11, 32'h0}) begin
      n_fail++;
      $display("FAIL timeout_rsp: rvalid=%b err=%b rdata=%h required 1 1 0",
               rvalid_o, err_o, rdata_o);
    end
    tick();
    late_resp = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if ({rvalid_o, mem_read, mem_write} !== 3'b000) begin
        n_fail++;
        $display("FAIL timeout_late: rvalid=%b rd=%b wr=%b required 000",
                 rvalid_o, mem_read, mem_write);
      end
      tick();
    end
    late_resp = 1'b0;
    resp_en   = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid_issue();
    resp_en = 1'b0;
    drive(32'h100, 1'b0, 4'hF, '0);
    tick();
    drive(32'h104, 1'b0, 4'hF, '0);
    @(negedge clk);
    n_checks++;
    if (gnt_o !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_gnt: got %b required 1", gnt_o);
    end
    tick();
    req_i = 1'b0;
    @(negedge clk);
    n_checks++;
    if (mem_read !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_issue: got rd=%b required 1", mem_read);
    end
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_checks++;
      if ({rvalid_o, mem_read, mem_write} !== 3'b000) begin
        n_fail++;
        $display("FAIL rstmid_quiet: cycle %0d rvalid=%b rd=%b wr=%b required 000",
                 i, rvalid_o, mem_read, mem_write);
      end
      tick();
    end
    resp_en    = 1'b1;
    resp_delay = 0;
    drive(32'h208, 1'b0, 4'hF, '0);
    @(negedge clk);
    tick();
    req_i = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({mem_read, mem_addr} !== {1'b1, 32'h208}) begin
      n_fail++;
      $display("FAIL rstmid_fresh_issue: rd=%b addr=%h required 1 208", mem_read, mem_addr);
    end
    tick();
    @(negedge clk);
    n_checks++;
    if ({rvalid_o, err_o, rdata_o} !== {2'b10, ref_mem[8'h82]}) begin
      n_fail++;
      $display("FAIL rstmid_fresh_rsp: rvalid=%b err=%b rdata=%h required 1 0 %h",
               rvalid_o, err_o, rdata_o, ref_mem[8'h82]);
    end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      memory[i]  = $urandom;
      ref_mem[i] = memory[i];
    end
    test_reset();
    test_single_read();
    test_write();
    test_back_to_back();
    test_timeout();
    test_reset_mid_issue();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
